instruction_fetch: RTL and testbench

- Fetch stage of the single-issue RV32I core; sits directly upstream of instruction_memory and downstream-feeds decode.
- Owns the program counter, drives the memory byte address, and registers the returned 32-bit word into an IF/ID pipeline register with valid/stall/flush control and branch redirect.
- Instruction memory reads are combinational: the word for O_imem_address is on I_imem_data in the same cycle.

---
 rtl/instruction_fetch.sv | 153 +++++++++++++++
 tb/tb_instruction_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage.
// Owns the PC, drives a combinational instruction memory and registers the
// returned word into the IF/ID register. Redirect, flush and stall are
// resolved in that order of priority.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN. When it is defined, a
// misaligned or out-of-range PC raises O_fault and the stage parks in HALT
// until reset.
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES   = 1024
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_stall,
  input  logic        I_flush,
  input  logic        I_redirect_valid,
  input  logic [31:0] I_redirect_target,
  output logic [31:0] O_imem_address,
  input  logic [31:0] I_imem_data,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic [31:0] O_pc_plus4,
  output logic        O_valid,
  output logic [31:0] O_fetch_count,
  output logic        O_fault
);

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [1:0]  S_BOOT = 2'b00;
  localparam logic [1:0]  S_RUN  = 2'b01;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [1:0]  S_HALT = 2'b10;
  // Highest address at which a whole word still fits in memory.
  localparam logic [31:0] PC_LAST = 32'(IMEM_BYTES - 4);
`endif

  // Memory size must hold at least one word and be a whole number of words.
  if (IMEM_BYTES < 4 || (IMEM_BYTES % 4) != 0) begin : g_bad_size
    $error("instruction_fetch: IMEM_BYTES must be a non-zero multiple of 4");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] opc4_q, opc4_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic        fault_q, fault_d;
  logic        pc_bad;

  assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q > PC_LAST);
`endif

  // PC arithmetic is plain 32-bit modulo; wrap past 0xFFFF_FFFC is intended.
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state logic: redirect > flush > stall > fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    opc4_d  = opc4_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d = fault_q;
`endif
    case (state_q)
      // One bubble after reset so memory sees the reset PC for a full cycle.
      S_BOOT: begin
        valid_d = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (I_redirect_valid) begin
          // Word currently on the bus is wrong-path; drop it.
          pc_d    = I_redirect_target;
          valid_d = 1'b0;
        end else if (I_flush) begin
          valid_d = 1'b0;
          if (!I_stall) pc_d = pc_plus4;
        end else if (!I_stall) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          if (pc_bad) begin
            fault_d = 1'b1;
            valid_d = 1'b0;
            state_d = S_HALT;
          end else
`endif
          begin
            instr_d = I_imem_data;
            opc_d   = pc_q;
            opc4_d  = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            cnt_d   = cnt_q + 32'd1;
          end
        end
      end
`ifdef FETCH_BOUNDS_CHECK_EN
      // Parked after a fault; only reset gets out.
      S_HALT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
`endif
      default: state_d = S_BOOT;
    endcase
  end

  // State and IF/ID register; async reset drops any pending redirect.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP;
      opc_q   <= 32'd0;
      opc4_q  <= 32'd0;
      cnt_q   <= 32'd0;
      valid_q <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      opc4_q  <= opc4_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign O_imem_address = pc_q;
  assign O_instr        = instr_q;
  assign O_pc           = opc_q;
  assign O_pc_plus4     = opc4_q;
  assign O_valid        = valid_q;
  assign O_fetch_count  = cnt_q;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign O_fault        = fault_q;
`else
  assign O_fault        = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven check of the fetch stage plus a
// delivery scoreboard and hand-written reset / bounds sequences.
module tb_instruction_fetch;

  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_stall = 1'b0;
  logic        I_flush = 1'b0;
  logic        I_redirect_valid = 1'b0;
  logic [31:0] I_redirect_target = 32'd0;
  logic [31:0] O_imem_address;
  logic [31:0] I_imem_data;
  logic [31:0] O_instr, O_pc, O_pc_plus4, O_fetch_count;
  logic        O_valid, O_fault;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch #(.RESET_VECTOR(32'h0), .IMEM_BYTES(1024)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_stall(I_stall), .I_flush(I_flush),
    .I_redirect_valid(I_redirect_valid), .I_redirect_target(I_redirect_target),
    .O_imem_address(O_imem_address), .I_imem_data(I_imem_data),
    .O_instr(O_instr), .O_pc(O_pc), .O_pc_plus4(O_pc_plus4), .O_valid(O_valid),
    .O_fetch_count(O_fetch_count), .O_fault(O_fault)
  );

  always #5 I_clk = ~I_clk;

  // Combinational memory model.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return a ^ 32'h1234_0013;
  endfunction

  assign I_imem_data = memf(O_imem_address);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        stall, flush, redir;
    logic [31:0] tgt;
    logic        valid;
    logic [31:0] pc, addr, cnt;
  } vec_t;

  vec_t        tv[$];
  logic [63:0] sb[$];

  function automatic vec_t mk(input logic s, input logic f, input logic r,
                              input logic [31:0] t, input logic v,
                              input logic [31:0] pc, input logic [31:0] ad,
                              input logic [31:0] c);
    vec_t x;
    x.stall = s; x.flush = f; x.redir = r; x.tgt = t;
    x.valid = v; x.pc = pc; x.addr = ad; x.cnt = c;
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev_exp, seen;
    logic [63:0] e;

    // stall flush redir target | valid O_pc addr count  (after the edge)
    tv.push_back(mk(0,0,0,32'h0,   0,32'h0,  32'h0,  0)); // BOOT bubble
    tv.push_back(mk(0,0,0,32'h0,   1,32'h0,  32'h4,  1));
    tv.push_back(mk(0,0,0,32'h0,   1,32'h4,  32'h8,  2));
    tv.push_back(mk(0,0,0,32'h0,   1,32'h8,  32'hC,  3));
    tv.push_back(mk(1,0,0,32'h0,   1,32'h8,  32'hC,  3)); // stall x3
    tv.push_back(mk(1,0,0,32'h0,   1,32'h8,  32'hC,  3));
    tv.push_back(mk(1,0,0,32'h0,   1,32'h8,  32'hC,  3));
    tv.push_back(mk(0,0,0,32'h0,   1,32'hC,  32'h10, 4));
    tv.push_back(mk(0,1,0,32'h0,   0,32'hC,  32'h14, 4)); // flush at PC=0x10
    tv.push_back(mk(0,0,0,32'h0,   1,32'h14, 32'h18, 5));
    tv.push_back(mk(1,0,1,32'h40,  0,32'h14, 32'h40, 5)); // redirect beats stall
    tv.push_back(mk(0,0,0,32'h0,   1,32'h40, 32'h44, 6));
    tv.push_back(mk(1,1,0,32'h0,   0,32'h40, 32'h44, 6)); // flush+stall: PC holds
    tv.push_back(mk(0,0,0,32'h0,   1,32'h44, 32'h48, 7));
    tv.push_back(mk(0,1,1,32'h100, 0,32'h44, 32'h100,7)); // redirect beats flush
    tv.push_back(mk(0,0,0,32'h0,   1,32'h100,32'h104,8));
`ifndef FETCH_BOUNDS_CHECK_EN
    tv.push_back(mk(0,0,1,32'hFFFF_FFFC, 0,32'h100,32'hFFFF_FFFC,8));
    tv.push_back(mk(0,0,0,32'h0,   1,32'hFFFF_FFFC,32'h0,9)); // wraps
    tv.push_back(mk(0,0,0,32'h0,   1,32'h0,  32'h4,  10));
`endif

    // Reset state.
    #12;
    chk("rst_addr",  O_imem_address, 32'h0);
    chk("rst_instr", O_instr, 32'h0000_0013);
    chk("rst_pc",    O_pc, 32'h0);
    chk("rst_pc4",   O_pc_plus4, 32'h0);
    chk("rst_valid", {31'd0, O_valid}, 32'h0);
    chk("rst_count", O_fetch_count, 32'h0);
    chk("rst_fault", {31'd0, O_fault}, 32'h0);

    @(negedge I_clk);
    I_rst_n = 1'b1;
    prev_exp = 0;
    seen = 0;
    foreach (tv[i]) begin
      if (i != 0) @(negedge I_clk);
      I_stall = tv[i].stall;
      I_flush = tv[i].flush;
      I_redirect_valid = tv[i].redir;
      I_redirect_target = tv[i].tgt;
      if (tv[i].cnt != prev_exp) sb.push_back({tv[i].pc, memf(tv[i].pc)});
      prev_exp = tv[i].cnt;
      @(posedge I_clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, O_valid}, {31'd0, tv[i].valid});
      chk($sformatf("v%0d_addr", i), O_imem_address, tv[i].addr);
      chk($sformatf("v%0d_count", i), O_fetch_count, tv[i].cnt);
      chk($sformatf("v%0d_fault", i), {31'd0, O_fault}, 32'h0);
      if (tv[i].valid) begin
        chk($sformatf("v%0d_pc", i), O_pc, tv[i].pc);
        chk($sformatf("v%0d_pc4", i), O_pc_plus4, tv[i].pc + 32'd4);
      end
      // Scoreboard: each new delivery must match the oldest expected one.
      if (O_fetch_count != seen) begin
        seen = O_fetch_count;
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_sb_unexpected", i), O_fetch_count, prev_exp - 32'd1);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d_sb_pc", i), O_pc, e[63:32]);
          chk($sformatf("v%0d_sb_instr", i), O_instr, e[31:0]);
        end
      end
    end
    chk("sb_drained", sb.size(), 32'd0);

    // Async reset in the middle of a stall with a redirect pending.
    @(negedge I_clk);
    I_stall = 1'b1;
    I_redirect_valid = 1'b1;
    I_redirect_target = 32'h80;
    #2 I_rst_n = 1'b0;
    #1;
    chk("mid_rst_addr",  O_imem_address, 32'h0);
    chk("mid_rst_valid", {31'd0, O_valid}, 32'h0);
    chk("mid_rst_count", O_fetch_count, 32'h0);
    chk("mid_rst_instr", O_instr, 32'h0000_0013);
    @(negedge I_clk);
    I_stall = 1'b0;
    I_redirect_valid = 1'b0;
    I_rst_n = 1'b1;
    @(posedge I_clk); #1;
    chk("reboot_valid", {31'd0, O_valid}, 32'h0);
    chk("reboot_addr",  O_imem_address, 32'h0);
    @(posedge I_clk); #1;
    chk("reboot_pc",    O_pc, 32'h0);
    chk("reboot_instr", O_instr, 32'h0050_0093);
    chk("reboot_count", O_fetch_count, 32'h1);

`ifdef FETCH_BOUNDS_CHECK_EN
    // Misaligned redirect target faults and parks the stage.
    @(negedge I_clk);
    I_redirect_valid = 1'b1;
    I_redirect_target = 32'h402;
    @(posedge I_clk); #1;
    chk("bc_addr1",  O_imem_address, 32'h402);
    chk("bc_valid1", {31'd0, O_valid}, 32'h0);
    @(negedge I_clk);
    I_redirect_valid = 1'b0;
    @(posedge I_clk); #1;
    chk("bc_fault",  {31'd0, O_fault}, 32'h1);
    chk("bc_valid2", {31'd0, O_valid}, 32'h0);
    chk("bc_addr2",  O_imem_address, 32'h402);
    @(negedge I_clk);
    I_redirect_valid = 1'b1;
    I_redirect_target = 32'h0;
    @(posedge I_clk); #1;
    chk("bc_halt_addr",  O_imem_address, 32'h402);
    chk("bc_halt_fault", {31'd0, O_fault}, 32'h1);
    @(negedge I_clk);
    I_redirect_valid = 1'b0;
    #2 I_rst_n = 1'b0;
    #1;
    chk("bc_rst_fault", {31'd0, O_fault}, 32'h0);
    chk("bc_rst_addr",  O_imem_address, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
